// File: rtl/logic_pod_capture_arbiter.sv
// Round-robin burst scheduler sharing one capture-memory write port between pod CDC FIFOs.
// Latency: pop one cycle after the burst grant, write one cycle after each pop; waits on mem_burst_ready at grant only.
module logic_pod_capture_arbiter #(
  parameter int NUM_PODS    = 4,
  parameter int BURST_LEN   = 8,
  parameter int CNT_BITS    = 10,
  parameter int REGION_BITS = 14,
  localparam int POD_W      = $clog2(NUM_PODS),
  localparam int LEN_W      = $clog2(BURST_LEN) + 1
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [NUM_PODS-1:0]               fifo_rd_en,
  input  logic [NUM_PODS*128-1:0]           fifo_rd_data,
  input  logic [NUM_PODS*CNT_BITS-1:0]      fifo_rd_size,
  input  logic                              mem_burst_ready,
  output logic                              mem_burst_start,
  output logic [LEN_W-1:0]                  mem_burst_len,
  output logic                              mem_wr_en,
  output logic [POD_W+REGION_BITS-1:0]      mem_wr_addr,
  output logic [127:0]                      mem_wr_data,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic [NUM_PODS-1:0]               pod_wrapped
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [CNT_BITS:0] BURST_CNT = (CNT_BITS+1)'(BURST_LEN);

  state_t                  state_q;
  logic [POD_W-1:0]        rr_q;
  logic [POD_W-1:0]        gnt_q;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt_q;
  logic                    flushing_q;
  logic [REGION_BITS-1:0]  wptr_q [NUM_PODS];
  logic [NUM_PODS-1:0]     wrapped_q;
  logic [NUM_PODS-1:0]     rd_en_q;
  logic                    start_q;
  logic [LEN_W-1:0]        burst_len_q;
  logic                    wr_en_q;
  logic                    flush_done_q;

  logic [NUM_PODS-1:0]     elig;
  logic [NUM_PODS-1:0]     has_data;
  logic [CNT_BITS-1:0]     size_p;
  logic [CNT_BITS-1:0]     pick_size;
  logic [POD_W:0]          idx;
  logic                    found_d;
  logic [POD_W-1:0]        gnt_d;
  logic [POD_W-1:0]        rr_d;
  logic [LEN_W-1:0]        len_d;
  logic [127:0]            rd_word;

  // Eligibility and the round-robin search starting at rr_q.
  always_comb begin
    elig      = '0;
    has_data  = '0;
    size_p    = '0;
    idx       = '0;
    found_d   = 1'b0;
    gnt_d     = '0;
    pick_size = '0;
    len_d     = LEN_W'(BURST_LEN);
    for (int p = 0; p < NUM_PODS; p++) begin
      size_p      = fifo_rd_size[p*CNT_BITS +: CNT_BITS];
      has_data[p] = (size_p != '0);
      elig[p]     = flushing_q ? (size_p != '0) : ({1'b0, size_p} >= BURST_CNT);
    end
    for (int i = 0; i < NUM_PODS; i++) begin
      idx = {1'b0, rr_q} + (POD_W+1)'(i);
      if (idx >= (POD_W+1)'(NUM_PODS)) begin
        idx = idx - (POD_W+1)'(NUM_PODS);
      end
      if (!found_d && elig[idx[POD_W-1:0]]) begin
        found_d = 1'b1;
        gnt_d   = idx[POD_W-1:0];
      end
    end
    pick_size = fifo_rd_size[gnt_d*CNT_BITS +: CNT_BITS];
    if (flushing_q && ({1'b0, pick_size} < BURST_CNT)) begin
      len_d = pick_size[LEN_W-1:0];
    end
    rr_d = (gnt_d == POD_W'(NUM_PODS-1)) ? '0 : gnt_d + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      flushing_q   <= 1'b0;
      wrapped_q    <= '0;
      rd_en_q      <= '0;
      start_q      <= 1'b0;
      burst_len_q  <= '0;
      wr_en_q      <= 1'b0;
      flush_done_q <= 1'b0;
      for (int p = 0; p < NUM_PODS; p++) begin
        wptr_q[p] <= '0;
      end
    end else begin
      start_q      <= 1'b0;
      burst_len_q  <= '0;
      flush_done_q <= 1'b0;
      wr_en_q      <= |rd_en_q;
      if (flush_req && !flushing_q) begin
        flushing_q <= 1'b1;
      end
      if (wr_en_q) begin
        wptr_q[gnt_q] <= wptr_q[gnt_q] + 1'b1;
        if (&wptr_q[gnt_q]) begin
          wrapped_q[gnt_q] <= 1'b1;
        end
      end
      // state_q runs one cycle ahead of the visible pop strobes.
      case (state_q)
        IDLE: begin
          rd_en_q <= '0;
          if (flushing_q && !(|has_data)) begin
            flush_done_q <= 1'b1;
            flushing_q   <= 1'b0;
          end else if (mem_burst_ready && found_d) begin
            start_q     <= 1'b1;
            burst_len_q <= len_d;
            len_q       <= len_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            cnt_q       <= '0;
            state_q     <= READ;
          end
        end
        READ: begin
          rd_en_q <= NUM_PODS'(1) << gnt_q;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q + 1'b1 == len_q) begin
            state_q <= DRAIN;
          end
        end
        default: begin
          rd_en_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd_word         = fifo_rd_data[gnt_q*128 +: 128];
  assign fifo_rd_en      = rd_en_q;
  assign mem_burst_start = start_q;
  assign mem_burst_len   = burst_len_q;
  assign mem_wr_en       = wr_en_q;
  assign mem_wr_addr     = wr_en_q ? {gnt_q, wptr_q[gnt_q]} : '0;
  assign mem_wr_data     = wr_en_q ? rd_word : '0;
  assign flush_done      = flush_done_q;
  assign pod_wrapped     = wrapped_q;

endmodule

// File: tb/tb_logic_pod_capture_arbiter.sv
// Bench for logic_pod_capture_arbiter: queue-backed pod FIFOs and a burst-schedule reference model.
module tb_logic_pod_capture_arbiter;
  localparam int NP = 4, BL = 8, CB = 10, RB = 4, RSZ = 16, AW = 6, LW = 4;
  localparam int BIG = 1 << 30;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NP-1:0]       fifo_rd_en;
  logic [NP*128-1:0]   fifo_rd_data;
  logic [NP*CB-1:0]    fifo_rd_size;
  logic                mem_burst_ready = 1'b0;
  logic                mem_burst_start;
  logic [LW-1:0]       mem_burst_len;
  logic                mem_wr_en;
  logic [AW-1:0]       mem_wr_addr;
  logic [127:0]        mem_wr_data;
  logic                flush_req = 1'b0;
  logic                flush_done;
  logic [NP-1:0]       pod_wrapped;

  logic_pod_capture_arbiter #(.NUM_PODS(NP), .BURST_LEN(BL), .CNT_BITS(CB), .REGION_BITS(RB)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_rd_size(fifo_rd_size), .mem_burst_ready(mem_burst_ready),
    .mem_burst_start(mem_burst_start), .mem_burst_len(mem_burst_len), .mem_wr_en(mem_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .flush_req(flush_req),
    .flush_done(flush_done), .pod_wrapped(pod_wrapped));

  always #5 clk = ~clk;

  // Pod FIFOs: pops take effect at the edge after the strobe, data valid the following cycle.
  logic [127:0] q [NP][$];
  logic [127:0] rdd [NP];
  logic [NP-1:0] pend;
  int  push_cnt [NP];
  bit  rst_in, rdy_in, fl_in;
  int  cyc, errors, checks;

  // Reference model: expected outputs keyed by cycle.
  int            e_start [int];
  logic [NP-1:0] e_rden  [int];
  int            e_addr  [int];
  logic [127:0]  e_data  [int];
  bit            e_fd    [int];
  int  m_rr, next_dec;
  int  m_wptr [NP];
  int  wrap_cyc [NP];
  bit  m_fl;

  int  last_start, last_len, wr_cnt, fd_cnt, first_addr;
  bit  start_prev;
  int  got_order [$];

  typedef struct packed {
    logic [31:0] sz;     // byte p = words loaded into pod p
    logic        flush;
    logic        flush2;
    logic [3:0]  ngr;
    logic [31:0] ord;    // nibble i = pod of grant i
    logic [3:0]  fd;
    logic [3:0]  wrap;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    e_start.delete(); e_rden.delete(); e_addr.delete(); e_data.delete(); e_fd.delete();
    m_rr = 0; next_dec = 0; m_fl = 0;
    for (int p = 0; p < NP; p++) begin m_wptr[p] = 0; wrap_cyc[p] = BIG; end
    last_start = -1; start_prev = 0;
  endtask

  task automatic model_eval();
    int sz [NP];
    bit any, found, fl_next;
    int g, len, ptr, p;
    if (rst) begin model_reset(); return; end
    fl_next = m_fl;
    if (flush_req && !m_fl) fl_next = 1;
    if (cyc >= next_dec) begin
      any = 0; found = 0; g = 0;
      for (int k = 0; k < NP; k++) begin sz[k] = q[k].size(); if (sz[k] > 0) any = 1; end
      if (m_fl && !any) begin
        e_fd[cyc+1] = 1;
        fl_next = 0;
      end else if (mem_burst_ready) begin
        for (int i = 0; i < NP; i++) begin
          p = (m_rr + i) % NP;
          if (!found && (m_fl ? sz[p] > 0 : sz[p] >= BL)) begin found = 1; g = p; end
        end
        if (found) begin
          len = (m_fl && sz[g] < BL) ? sz[g] : BL;
          e_start[cyc+1] = len;
          for (int i = 0; i < len; i++) begin
            ptr = (m_wptr[g] + i) % RSZ;
            e_rden[cyc+2+i] = NP'(1) << g;
            e_addr[cyc+3+i] = g * RSZ + ptr;
            e_data[cyc+3+i] = q[g][i];
            if (ptr == RSZ - 1 && wrap_cyc[g] > cyc + 4 + i) wrap_cyc[g] = cyc + 4 + i;
          end
          m_wptr[g] = (m_wptr[g] + len) % RSZ;
          m_rr = (g + 1) % NP;
          next_dec = cyc + len + 2;
        end
      end
    end
    m_fl = fl_next;
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      fifo_rd_data[p*128 +: 128] = rdd[p];
      fifo_rd_size[p*CB +: CB]   = CB'(q[p].size());
    end
  endtask

  task automatic check_cycle();
    bit es, ew, ef;
    logic [NP-1:0] wexp;
    es = e_start.exists(cyc);
    ew = e_addr.exists(cyc);
    ef = e_fd.exists(cyc);
    for (int p = 0; p < NP; p++) wexp[p] = (wrap_cyc[p] <= cyc);
    chk("burst_start", 128'(mem_burst_start), 128'(es));
    chk("burst_len", 128'(mem_burst_len), es ? 128'(e_start[cyc]) : 128'(0));
    chk("rd_en", 128'(fifo_rd_en), e_rden.exists(cyc) ? 128'(e_rden[cyc]) : 128'(0));
    chk("wr_en", 128'(mem_wr_en), 128'(ew));
    chk("wr_addr", 128'(mem_wr_addr), ew ? 128'(e_addr[cyc]) : 128'(0));
    chk("wr_data", mem_wr_data, ew ? e_data[cyc] : 128'(0));
    chk("flush_done", 128'(flush_done), 128'(ef));
    chk("pod_wrapped", 128'(pod_wrapped), 128'(wexp));
    if (start_prev) begin
      for (int p = 0; p < NP; p++) if (fifo_rd_en[p]) got_order.push_back(p);
    end
    start_prev = mem_burst_start;
    if (mem_burst_start) begin
      if (last_start >= 0) chk("start_gap_ok", 128'((cyc - last_start) >= last_len + 2), 128'(1));
      last_start = cyc;
      last_len   = int'(mem_burst_len);
    end
    if (mem_wr_en) begin
      wr_cnt++;
      if (first_addr < 0) first_addr = int'(mem_wr_addr);
    end
    if (flush_done) fd_cnt++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    for (int p = 0; p < NP; p++) if (pend[p] && q[p].size() > 0) rdd[p] = q[p].pop_front();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < push_cnt[p]; k++) q[p].push_back({$urandom(), $urandom(), $urandom(), $urandom()});
    rst = rst_in; mem_burst_ready = rdy_in; flush_req = fl_in;
    drive();
    model_eval();
    @(negedge clk);
    check_cycle();
    pend = fifo_rd_en;
  endtask

  task automatic clear_pushes();
    for (int p = 0; p < NP; p++) push_cnt[p] = 0;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0; pend = '0;
    rst_in = 1; rdy_in = 0; fl_in = 0; wr_cnt = 0; fd_cnt = 0; first_addr = -1;
    for (int p = 0; p < NP; p++) begin rdd[p] = '0; push_cnt[p] = 0; end
    drive();
    model_reset();

    vecs[0] = '{sz:32'h00000800, flush:1'b0, flush2:1'b0, ngr:4'd1, ord:32'h1,        fd:4'd0, wrap:4'b0000};
    vecs[1] = '{sz:32'h10101010, flush:1'b0, flush2:1'b0, ngr:4'd8, ord:32'h32103210, fd:4'd0, wrap:4'b1111};
    vecs[2] = '{sz:32'h00080003, flush:1'b1, flush2:1'b0, ngr:4'd2, ord:32'h02,       fd:4'd1, wrap:4'b0000};
    vecs[3] = '{sz:32'h00000000, flush:1'b1, flush2:1'b1, ngr:4'd0, ord:32'h0,        fd:4'd1, wrap:4'b0000};
    vecs[4] = '{sz:32'h18000000, flush:1'b0, flush2:1'b0, ngr:4'd3, ord:32'h333,      fd:4'd0, wrap:4'b1000};
    vecs[5] = '{sz:32'h00000705, flush:1'b0, flush2:1'b0, ngr:4'd0, ord:32'h0,        fd:4'd0, wrap:4'b0000};
    vecs[6] = '{sz:32'h00110009, flush:1'b1, flush2:1'b0, ngr:4'd5, ord:32'h22020,    fd:4'd1, wrap:4'b0100};

    for (int v = 0; v < 7; v++) begin
      rst_in = 1; rdy_in = 1; fl_in = 0;
      for (int p = 0; p < NP; p++) begin q[p].delete(); push_cnt[p] = int'(vecs[v].sz[p*8 +: 8]); end
      step();
      clear_pushes();
      step();
      rst_in = 0; got_order.delete(); fd_cnt = 0;
      fl_in = vecs[v].flush;  step();
      fl_in = vecs[v].flush2; step();
      fl_in = 0;
      repeat (140) step();
      chk("grant_count", 128'(got_order.size()), 128'(vecs[v].ngr));
      for (int i = 0; i < int'(vecs[v].ngr); i++)
        chk("grant_order", (i < got_order.size()) ? 128'(got_order[i]) : 128'(99), 128'(vecs[v].ord[i*4 +: 4]));
      chk("flush_done_count", 128'(fd_cnt), 128'(vecs[v].fd));
      chk("pod_wrapped_end", 128'(pod_wrapped), 128'(vecs[v].wrap));
    end

    // Randomized traffic with backpressure, flushes and occasional resets.
    rst_in = 1;
    for (int p = 0; p < NP; p++) q[p].delete();
    step(); step();
    rst_in = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++)
        push_cnt[p] = ((c % 600) < 420 && q[p].size() < 100) ? int'($urandom_range(0, 1)) : 0;
      rdy_in = ($urandom_range(0, 3) != 0);
      fl_in  = ($urandom_range(0, 39) == 0);
      rst_in = ($urandom_range(0, 999) == 0);
      step();
    end
    clear_pushes(); rst_in = 0; fl_in = 0; rdy_in = 1;

    // Asynchronous reset during the fourth word of a burst.
    rst_in = 1;
    for (int p = 0; p < NP; p++) q[p].delete();
    push_cnt[0] = 8;
    step();
    clear_pushes();
    step();
    rst_in = 0; wr_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (wr_cnt >= 4) break;
      step();
    end
    chk("mid_reset_reached_word4", 128'(wr_cnt), 128'(4));
    rst = 1; rst_in = 1; pend = '0;
    #1;
    chk("mid_reset_rd_en_drop", 128'(fifo_rd_en), 128'(0));
    chk("mid_reset_wr_en_drop", 128'(mem_wr_en), 128'(0));
    model_reset();
    step(); step();
    rst_in = 0; fd_cnt = 0; first_addr = -1;
    push_cnt[0] = 4;
    step();
    clear_pushes();
    repeat (20) step();
    chk("post_reset_no_flush_done", 128'(fd_cnt), 128'(0));
    chk("post_reset_first_addr", 128'(first_addr), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_pod_capture_arbiter.md
Name: logic_pod_capture_arbiter

Overview:
- Round-robin scheduler that shares one memory write port between NUM_PODS logic-pod CDC FIFOs.
- Each FIFO holds 128-bit deserialized sample words.
- Each pod owns a circular region of the capture buffer. The block issues fixed-length bursts in normal operation and drains partial bursts on flush.
- Sits between the per-pod CDC FIFO read sides and the capture memory writer, in the memory clock domain.

Parameters:
- NUM_PODS, 4, number of pod FIFOs arbitrated (2..8).
- BURST_LEN, 8, words per full burst; power of two.
- CNT_BITS, 10, width of each FIFO rd_size input.
- REGION_BITS, 14, log2 of words per pod region. Write pointer width.

Ports:
- clk  in  1  memory-domain clock.
- rst  in  1  asynchronous, active-high reset.
- fifo_rd_en  out  NUM_PODS  pop strobe, one bit per pod.
- fifo_rd_data  in  NUM_PODS*128  pod p occupies bits [p*128 +: 128]. Valid one cycle after fifo_rd_en.
- fifo_rd_size  in  NUM_PODS*CNT_BITS  words available per pod; pod p at [p*CNT_BITS +: CNT_BITS].
- mem_burst_ready  in  1  writer can accept a complete burst starting next cycle.
- mem_burst_start  out  1  one-cycle strobe at burst grant.
- mem_burst_len  out  log2(BURST_LEN)+1  word count of the granted burst. Valid with mem_burst_start.
- mem_wr_en  out  1  data word valid.
- mem_wr_addr  out  $clog2(NUM_PODS)+REGION_BITS  {pod, wptr}.
- mem_wr_data  out  128  data word.
- flush_req  in  1  one-cycle request to drain all FIFOs.
- flush_done  out  1  one-cycle pulse when the drain is complete.
- pod_wrapped  out  NUM_PODS  sticky flag per pod: its region write pointer has wrapped.

Behaviour:
- Reset values: all outputs 0; all wptr 0; rr pointer 0; flushing 0; state IDLE.
- Reset is asynchronous and may assert mid-burst. The burst is abandoned and no further mem_wr_en is issued.
- States: IDLE, READ, DRAIN.
- Eligibility:
  - Normal mode: pod eligible if rd_size >= BURST_LEN.
  - Flushing: pod eligible if rd_size > 0.
- IDLE, grant:
  - Grant occurs when mem_burst_ready=1 and at least one pod is eligible.
  - Pick the first eligible pod searching from rr upward, modulo NUM_PODS. Then rr <= granted+1 (wraps).
  - Granted length: BURST_LEN, or min(rd_size, BURST_LEN) when flushing. Latch the length.
  - Same cycle: mem_burst_start=1, mem_burst_len=len. Go to READ.
- READ:
  - fifo_rd_en[g]=1 for exactly len consecutive cycles, starting the cycle after grant.
  - Each pop is followed one cycle later by mem_wr_en=1, mem_wr_data=that pod's rd_data, and mem_wr_addr={g, wptr[g]}.
  - Then wptr[g] increments, wrapping modulo 2^REGION_BITS. On the wrap from all-ones to 0, pod_wrapped[g] <= 1; it clears only on rst.
  - After the last pop, go to DRAIN.
- DRAIN: emit the final word, then return to IDLE. Burst grant-to-grant minimum is len+2 cycles.
- Flush:
  - flush_req while not flushing sets flushing=1 on the next cycle. flush_req while flushing is ignored.
  - flushing is only tested in IDLE; an in-progress full burst completes unchanged.
  - In IDLE with flushing=1 and no pod having rd_size>0: flush_done=1 for one cycle, flushing <= 0.
  - The no-data check does not depend on mem_burst_ready.
- fifo_rd_size is sampled only at grant. Growth during a burst does not extend it. Pods must never report more than actually stored.
- mem_wr_en never asserts outside READ/DRAIN. fifo_rd_en is one-hot or zero.
- Simultaneous eligibility: strict round robin. With all pods continuously eligible, grants cycle 0,1,2,3,0.

Test Plan:
- Pod1 rd_size=8, others 0, mem_burst_ready=1 -> mem_burst_start with len=8. Eight rd_en[1] pops, then eight mem_wr_en at addr {1,0}..{1,7}, data matching the FIFO in order. rr=2.
- All pods rd_size=16 held -> grants 0,1,2,3,0,1,2,3. Each pod's wptr ends at 16. No gap shorter than 10 cycles between mem_burst_start pulses.
- Pod0 rd_size=3, pod2 rd_size=8, flush_req pulse -> full burst pod2 (8), then partial burst pod0 (len=3). When all sizes are 0, flush_done pulses exactly once.
- flush_req with all rd_size=0 -> flush_done two cycles later, with no mem activity. A second flush_req during flushing -> no extra flush_done.
- REGION_BITS=4, 3 bursts of 8 on pod3 -> addresses wrap 15->0. pod_wrapped[3]=1 after word 16 and stays set.
- rst asserted during the 4th word of a burst -> rd_en/mem_wr_en drop immediately. After release: state IDLE, wptr 0, no flush_done.
